ex_muldiv_unit: RTL and testbench

//  Multi-cycle RV32M multiply/divide unit in the EX stage, fed by the ID/EX register outputs (funct3E, forwarded SrcAE/SrcBE).

---
 rtl/riscv_pkg.sv | 23 ++
 rtl/muldiv_step.sv | 33 +++
 rtl/ex_muldiv_unit.sv | 141 ++++++++++++++
 tb/tb_ex_muldiv_unit.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32 encodings used by the EX stage, plus the multiply/divide FSM encoding.
package riscv_pkg;

  localparam logic [6:0] OP_RTYPE      = 7'b0110011;
  localparam logic [6:0] OP_JAL        = 7'b1101111;
  localparam logic [6:0] OP_JALR       = 7'b1100111;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef logic [1:0] md_state_t;
  localparam md_state_t ST_IDLE = 2'd0;
  localparam md_state_t ST_RUN  = 2'd1;
  localparam md_state_t ST_DONE = 2'd2;

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration on the 2*XLEN accumulator: a shift-add multiply step
// (multiplier in the low half) or a restoring-divide step (remainder high, quotient low).
module muldiv_step #(
  parameter int XLEN = 32
) (
  input  logic              is_div,
  input  logic [XLEN-1:0]   b,
  input  logic [2*XLEN-1:0] acc_i,
  output logic [2*XLEN-1:0] acc_o
);

  logic [XLEN:0] sum;
  logic [XLEN:0] rem;
  logic [XLEN:0] diff;

  always_comb begin
    sum  = {1'b0, acc_i[2*XLEN-1:XLEN]} + {1'b0, b};
    // Partial remainder shifted left by one, pulling in the next dividend bit.
    rem  = acc_i[2*XLEN-1:XLEN-1];
    diff = rem - {1'b0, b};
    acc_o = '0;
    if (is_div) begin
      // The remainder stays below b, so diff[XLEN] is exactly the borrow.
      if (!diff[XLEN]) acc_o = {diff[XLEN-1:0], acc_i[XLEN-2:0], 1'b1};
      else             acc_o = {rem[XLEN-1:0],  acc_i[XLEN-2:0], 1'b0};
    end else if (acc_i[0]) begin
      acc_o = {sum, acc_i[XLEN-1:1]};
    end else begin
      acc_o = {1'b0, acc_i[2*XLEN-1:1]};
    end
  end

endmodule

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide for the EX stage: stalls the pipe via BusyE while
// iterating and presents ResultE for one cycle with DoneE.
module ex_muldiv_unit
  import riscv_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int ITER_STEP = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            MulDivE,
  input  logic [2:0]      funct3E,
  input  logic [XLEN-1:0] SrcAE,
  input  logic [XLEN-1:0] SrcBE,
  input  logic            KillE,
  output logic            BusyE,
  output logic            DoneE,
  output logic [XLEN-1:0] ResultE,
  output md_state_t       state_dbg
);

  localparam int N_IT = XLEN / ITER_STEP;
  localparam int CW   = $clog2(N_IT) + 1;
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  md_state_t         state_q;
  logic [CW-1:0]     cnt_q;
  logic [2*XLEN-1:0] acc_q;
  logic [XLEN-1:0]   b_q;
  logic              neg_lo_q;
  logic              neg_hi_q;
  logic [2:0]        op_q;

  logic              is_div, a_signed, b_signed, a_neg, b_neg;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic              div_zero, div_ovf, fast, launch;
  logic [2*XLEN-1:0] fast_acc;

  always_comb begin
    is_div   = funct3E[2];
    a_signed = (funct3E == F3_MULH) || (funct3E == F3_MULHSU) ||
               (funct3E == F3_DIV)  || (funct3E == F3_REM);
    b_signed = (funct3E == F3_MULH) || (funct3E == F3_DIV) || (funct3E == F3_REM);
    a_neg    = a_signed & SrcAE[XLEN-1];
    b_neg    = b_signed & SrcBE[XLEN-1];
    a_mag    = a_neg ? -SrcAE : SrcAE;
    b_mag    = b_neg ? -SrcBE : SrcBE;
    div_zero = is_div && (SrcBE == '0);
    div_ovf  = is_div && !funct3E[0] && (SrcAE == INT_MIN) && (SrcBE == '1);
    fast     = div_zero | div_ovf;
    launch   = (state_q == ST_IDLE) && MulDivE && !KillE;
    // Fast results are parked as {remainder, quotient} so DONE reads them like a real divide.
    if (div_zero) fast_acc = {SrcAE, {XLEN{1'b1}}};
    else          fast_acc = {{XLEN{1'b0}}, INT_MIN};
  end

  logic [2*XLEN-1:0] step_out;

  for (genvar g = 0; g < ITER_STEP; g++) begin : g_step
    logic [2*XLEN-1:0] acc_i;
    logic [2*XLEN-1:0] acc_o;
    if (g == 0) begin : g_first
      assign acc_i = acc_q;
    end else begin : g_next
      assign acc_i = g_step[g-1].acc_o;
    end
    muldiv_step #(.XLEN(XLEN)) u_step (
      .is_div (op_q[2]),
      .b      (b_q),
      .acc_i  (acc_i),
      .acc_o  (acc_o)
    );
  end

  assign step_out = g_step[ITER_STEP-1].acc_o;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      b_q      <= '0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      op_q     <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (launch) begin
            op_q <= funct3E;
            if (fast) begin
              acc_q    <= fast_acc;
              neg_lo_q <= 1'b0;
              neg_hi_q <= 1'b0;
              state_q  <= ST_DONE;
            end else begin
              acc_q    <= {{XLEN{1'b0}}, a_mag};
              b_q      <= b_mag;
              neg_lo_q <= a_neg ^ b_neg;
              neg_hi_q <= a_neg;
              cnt_q    <= '0;
              state_q  <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          if (KillE) begin
            state_q <= ST_IDLE;
          end else begin
            acc_q <= step_out;
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == CW'(N_IT - 1)) state_q <= ST_DONE;
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quot_fix, rem_fix, res;

  always_comb begin
    prod_fix = neg_lo_q ? -acc_q : acc_q;
    quot_fix = neg_lo_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    rem_fix  = neg_hi_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    case (op_q)
      F3_MUL:                        res = prod_fix[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU:  res = prod_fix[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU:               res = quot_fix;
      default:                       res = rem_fix;
    endcase
  end

  assign BusyE     = rst_n && ((launch && !fast) || (state_q == ST_RUN));
  assign DoneE     = rst_n && (state_q == ST_DONE);
  assign ResultE   = DoneE ? res : '0;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed bench for ex_muldiv_unit: drivers push expected results, a negedge monitor
// pops them whenever DoneE is seen; latency, abort and reset behaviour are checked inline.
module tb_ex_muldiv_unit;
  import riscv_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        MulDivE;
  logic [2:0]  funct3E;
  logic [31:0] SrcAE;
  logic [31:0] SrcBE;
  logic        KillE;
  logic        BusyE;
  logic        DoneE;
  logic [31:0] ResultE;
  md_state_t   state_dbg;

  logic [31:0] exp_q[$];
  int total = 0;
  int bad   = 0;

  ex_muldiv_unit #(.XLEN(32), .ITER_STEP(1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .MulDivE   (MulDivE),
    .funct3E   (funct3E),
    .SrcAE     (SrcAE),
    .SrcBE     (SrcBE),
    .KillE     (KillE),
    .BusyE     (BusyE),
    .DoneE     (DoneE),
    .ResultE   (ResultE),
    .state_dbg (state_dbg)
  );

  // clock / watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp_v);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (rst_n && DoneE) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        check("result", ResultE, exp_q.pop_front());
      end
    end
  end

  // drivers
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      MulDivE = 1'b0;
      KillE   = 1'b0;
    end
  endtask

  task automatic run_op(input string nm, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res,
                        input bit is_fast, input bit chg);
    int busy_n;
    int done_cyc;
    busy_n   = 0;
    done_cyc = -1;
    exp_q.push_back(exp_res);
    @(posedge clk); #1;
    MulDivE = 1'b1;
    funct3E = f3;
    SrcAE   = a;
    SrcBE   = b;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (BusyE) busy_n++;
      if (DoneE) begin
        done_cyc = c;
        break;
      end
      @(posedge clk); #1;
      if (chg) begin
        SrcAE = $urandom;
        SrcBE = $urandom_range(0, 1000);
      end
    end
    if (done_cyc < 0) begin
      check({nm, "_timeout"}, 32'd1, 32'd0);
    end else begin
      check({nm, "_done_cycle"}, done_cyc, is_fast ? 32'd1 : 32'd33);
      check({nm, "_busy_cycles"}, busy_n, is_fast ? 32'd0 : 32'd33);
    end
  endtask

  task automatic abort_run(input string nm, input bit use_rst);
    int noisy;
    noisy = 0;
    @(posedge clk); #1;
    MulDivE = 1'b1;
    funct3E = F3_DIV;
    SrcAE   = 32'hFFFF_FFF9;
    SrcBE   = 32'd2;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
    end
    if (use_rst) rst_n = 1'b0;
    else         KillE = 1'b1;
    @(negedge clk);
    check({nm, "_busy_at_abort"}, BusyE, use_rst ? 32'd0 : 32'd1);
    @(posedge clk); #1;
    rst_n   = 1'b1;
    KillE   = 1'b0;
    MulDivE = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (BusyE || DoneE || (ResultE != 32'd0)) noisy++;
      @(posedge clk); #1;
    end
    check({nm, "_quiet_cycles"}, noisy, 32'd0);
    check({nm, "_state_idle"}, state_dbg, ST_IDLE);
  endtask

  initial begin
    rst_n   = 1'b0;
    MulDivE = 1'b1;
    funct3E = F3_MUL;
    SrcAE   = 32'd3;
    SrcBE   = 32'd5;
    KillE   = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", BusyE, 32'd0);
    check("rst_done", DoneE, 32'd0);
    check("rst_result", ResultE, 32'd0);
    check("rst_state", state_dbg, ST_IDLE);
    @(posedge clk); #1;
    rst_n   = 1'b1;
    MulDivE = 1'b0;
    idle(2);

    run_op("mul",    F3_MUL,    32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, 1'b0); idle(2);
    run_op("mulh",   F3_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0, 1'b0); idle(1);
    run_op("mulhu",  F3_MULHU,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0, 1'b0); idle(1);
    run_op("mulhsu", F3_MULHSU, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 1'b0, 1'b0); idle(1);
    run_op("div",    F3_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 1'b0, 1'b0); idle(1);
    run_op("rem",    F3_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 1'b0, 1'b0); idle(1);
    run_op("divu",   F3_DIVU,   32'd100,       32'd7,         32'd14,        1'b0, 1'b0); idle(1);
    run_op("remu",   F3_REMU,   32'd100,       32'd7,         32'd2,         1'b0, 1'b0); idle(1);

    run_op("divu_by0", F3_DIVU, 32'd5,         32'd0,         32'hFFFF_FFFF, 1'b1, 1'b0); idle(1);
    run_op("rem_by0",  F3_REM,  32'd7,         32'd0,         32'd7,         1'b1, 1'b0); idle(1);
    run_op("div_ovf",  F3_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 1'b0); idle(1);
    run_op("rem_ovf",  F3_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1'b1, 1'b0); idle(1);

    // kill while idle must not launch
    @(posedge clk); #1;
    MulDivE = 1'b1;
    KillE   = 1'b1;
    funct3E = F3_DIVU;
    SrcAE   = 32'd50;
    SrcBE   = 32'd5;
    @(negedge clk);
    check("kill_idle_busy", BusyE, 32'd0);
    @(posedge clk); #1;
    MulDivE = 1'b0;
    KillE   = 1'b0;
    @(negedge clk);
    check("kill_idle_state", state_dbg, ST_IDLE);
    idle(1);

    abort_run("kill", 1'b0);
    abort_run("reset", 1'b1);
    idle(1);

    run_op("b2b_mul",  F3_MUL,  32'd3, 32'd4, 32'd12, 1'b0, 1'b1);
    run_op("b2b_divu", F3_DIVU, 32'd9, 32'd3, 32'd3,  1'b0, 1'b1);
    idle(4);

    check("queue_drained", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
